// File: rtl/shwr_area_capture_pkg.sv
// Shared types and widths for the shower area capture block.
// The trigger-wide defines normally come from sde_trigger_defs.vh; defaults
// are supplied here so the package also elaborates without that header.
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef SHWR_AREA_FRAC_WIDTH
`define SHWR_AREA_FRAC_WIDTH 4
`endif
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 20
`endif
`ifndef SHWR_AREA_BINS
`define SHWR_AREA_BINS 250
`endif
`ifndef SHWR_CAPTURE_DEPTH
`define SHWR_CAPTURE_DEPTH 4
`endif

package shwr_area_capture_pkg;

    localparam int ADC_W         = `ADC_WIDTH;
    localparam int FRAC_W        = `SHWR_AREA_FRAC_WIDTH;
    localparam int AREA_W        = `SHWR_AREA_WIDTH;
    localparam int AREA_BINS     = `SHWR_AREA_BINS;
    localparam int CAPTURE_DEPTH = `SHWR_CAPTURE_DEPTH;

    localparam int INTEGRAL_W = AREA_W + FRAC_W;
    localparam int BASELINE_W = ADC_W + FRAC_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CAPTURE,
        WAIT_LOW
    } cap_state_t;

    // One captured shower result, as stored in the result FIFO.
    typedef struct packed {
        logic [INTEGRAL_W-1:0] area;
        logic [BASELINE_W-1:0] baseline;
        logic [ADC_W-1:0]      peak;
        logic                  sat;
        logic [1:0]            buf_num;
    } shwr_result_t;

endpackage

// File: rtl/shwr_area_capture_if.sv
// Integrator-side inputs, FIFO read controls and FIFO head/status outputs.
interface shwr_area_capture_if
    import shwr_area_capture_pkg::*;
#(
    parameter int DEPTH = CAPTURE_DEPTH
);
    logic                      TRIGGERED;
    logic [1:0]                BUF_NUM;
    logic [INTEGRAL_W-1:0]     INTEGRAL;
    logic [BASELINE_W-1:0]     BASELINE;
    logic [ADC_W-1:0]          PEAK;
    logic                      SATURATED;
    logic                      RD_EN;
    logic                      CLR_OVERFLOW;

    logic [INTEGRAL_W-1:0]     AREA_OUT;
    logic [BASELINE_W-1:0]     BASELINE_OUT;
    logic [ADC_W-1:0]          PEAK_OUT;
    logic                      SAT_OUT;
    logic [1:0]                BUF_NUM_OUT;
    logic                      EMPTY;
    logic                      FULL;
    logic [$clog2(DEPTH):0]    COUNT;
    logic                      OVERFLOW;

    modport master (
        output TRIGGERED, BUF_NUM, INTEGRAL, BASELINE, PEAK, SATURATED, RD_EN, CLR_OVERFLOW,
        input  AREA_OUT, BASELINE_OUT, PEAK_OUT, SAT_OUT, BUF_NUM_OUT, EMPTY, FULL, COUNT, OVERFLOW
    );

    modport slave (
        input  TRIGGERED, BUF_NUM, INTEGRAL, BASELINE, PEAK, SATURATED, RD_EN, CLR_OVERFLOW,
        output AREA_OUT, BASELINE_OUT, PEAK_OUT, SAT_OUT, BUF_NUM_OUT, EMPTY, FULL, COUNT, OVERFLOW
    );

endinterface

// File: rtl/shwr_result_fifo.sv
// Result FIFO with a registered show-ahead head and a sticky overflow flag.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module shwr_result_fifo
    import shwr_area_capture_pkg::*;
#(
    parameter int DEPTH = CAPTURE_DEPTH
) (
    input  logic                   CLK120,
    input  logic                   RESET,
    input  logic                   wr_en_i,
    input  shwr_result_t           wr_data_i,
    input  logic                   rd_en_i,
    input  logic                   clr_overflow_i,
    output shwr_result_t           head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

    shwr_result_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
    logic [PTR_W:0]   count_q, count_d;
    shwr_result_t     head_q, head_d;
    logic             overflow_q, overflow_d;
    logic             pop, push, drop;

    assign pop       = rd_en_i && (count_q != '0);
    assign push      = wr_en_i && ((count_q != FULL_CNT) || pop);
    assign drop      = wr_en_i && !push;
    assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);

    // Next occupancy, next head entry and next overflow state.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        // The head only moves on a pop or on the first write into an empty
        // FIFO; when the last entry is popped with no write it keeps its value.
        head_d = head_q;
        if (pop) begin
            if (count_q > ONE_CNT) begin
                head_d = mem_q[rd_ptr_nx];
            end else if (push) begin
                head_d = wr_data_i;
            end
        end else if (push && (count_q == '0)) begin
            head_d = wr_data_i;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    // Entry storage; a full-FIFO write with a pop lands in the slot just popped.
    always_ff @(posedge CLK120) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, occupancy, head register and overflow flag.
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nx;
            end
            count_q    <= count_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    assign head_o     = head_q;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign overflow_o = overflow_q;

endmodule

// File: rtl/shwr_area_capture.sv
// Captures one integrator result per shower trigger once the integration
// window and settling time have elapsed, and queues it in the result FIFO.
module shwr_area_capture
    import shwr_area_capture_pkg::*;
#(
    parameter int DEPTH  = CAPTURE_DEPTH,
    parameter int SETTLE = 2
) (
    input  logic               CLK120,
    input  logic               RESET,
    shwr_area_capture_if.slave bus
);
    // Counter value at which the integrator outputs are stable to sample.
    localparam int CAPTURE_AT = AREA_BINS + 1 + SETTLE;
    localparam int CNT_W      = $clog2(CAPTURE_AT + 1);
    localparam logic [CNT_W-1:0] LAST_ACCUM = CNT_W'(CAPTURE_AT - 1);

    cap_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              trig_q;
    logic [1:0]        buf_num_q;
    logic              cap_wr_q;
    logic              trig_rise;
    shwr_result_t      wr_data;
    shwr_result_t      head;

    assign trig_rise = bus.TRIGGERED && !trig_q;

    // Event window sequencing: edge detect, window count, one-cycle capture.
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
            buf_num_q <= '0;
            cap_wr_q  <= 1'b0;
        end else begin
            trig_q   <= bus.TRIGGERED;
            cap_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig_rise) begin
                        state_q   <= ACCUM;
                        cnt_q     <= CNT_W'(1);
                        buf_num_q <= bus.BUF_NUM;
                    end
                end
                ACCUM: begin
                    if (!bus.TRIGGERED) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_ACCUM) begin
                            state_q  <= CAPTURE;
                            cap_wr_q <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    state_q <= WAIT_LOW;
                    cnt_q   <= '0;
                end
                WAIT_LOW: begin
                    if (!bus.TRIGGERED) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign wr_data.area     = bus.INTEGRAL;
    assign wr_data.baseline = bus.BASELINE;
    assign wr_data.peak     = bus.PEAK;
    assign wr_data.sat      = bus.SATURATED;
    assign wr_data.buf_num  = buf_num_q;

    shwr_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK120         (CLK120),
        .RESET          (RESET),
        .wr_en_i        (cap_wr_q),
        .wr_data_i      (wr_data),
        .rd_en_i        (bus.RD_EN),
        .clr_overflow_i (bus.CLR_OVERFLOW),
        .head_o         (head),
        .empty_o        (bus.EMPTY),
        .full_o         (bus.FULL),
        .count_o        (bus.COUNT),
        .overflow_o     (bus.OVERFLOW)
    );

    assign bus.AREA_OUT     = head.area;
    assign bus.BASELINE_OUT = head.baseline;
    assign bus.PEAK_OUT     = head.peak;
    assign bus.SAT_OUT      = head.sat;
    assign bus.BUF_NUM_OUT  = head.buf_num;

endmodule

// File: tb/tb_shwr_area_capture.sv
// Directed bench for shwr_area_capture with a result scoreboard.
module tb_shwr_area_capture;
    import shwr_area_capture_pkg::*;

    logic CLK120 = 1'b0;
    logic RESET;

    always #4 CLK120 = ~CLK120;

    shwr_area_capture_if #(.DEPTH(CAPTURE_DEPTH)) bus ();

    shwr_area_capture #(
        .DEPTH  (CAPTURE_DEPTH),
        .SETTLE (2)
    ) dut (
        .CLK120 (CLK120),
        .RESET  (RESET),
        .bus    (bus)
    );

    int           checks   = 0;
    int           failures = 0;
    shwr_result_t sb[$];
    logic         model_ovf = 1'b0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK120);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic shwr_result_t dut_head();
        shwr_result_t h;
        h.area     = bus.AREA_OUT;
        h.baseline = bus.BASELINE_OUT;
        h.peak     = bus.PEAK_OUT;
        h.sat      = bus.SAT_OUT;
        h.buf_num  = bus.BUF_NUM_OUT;
        return h;
    endfunction

    function automatic shwr_result_t mk(input int i);
        shwr_result_t r;
        r.area     = INTEGRAL_W'(24'h100000 + i * 24'h001111);
        r.baseline = BASELINE_W'(16'h0800 + i);
        r.peak     = ADC_W'(12'h100 + i * 7);
        r.sat      = 1'(i);
        r.buf_num  = 2'(i);
        return r;
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_count"}, 64'(bus.COUNT), 64'(sb.size()));
        check({tag, "_empty"}, 64'(bus.EMPTY), 64'(sb.size() == 0));
        check({tag, "_full"}, 64'(bus.FULL), 64'(sb.size() == CAPTURE_DEPTH));
        check({tag, "_ovf"}, 64'(bus.OVERFLOW), 64'(model_ovf));
    endtask

    // One full event; the integrator values are only valid on the capture cycle.
    task automatic run_event(input string tag, input shwr_result_t r,
                             input logic pop_at_cap, input logic clr_at_cap);
        logic drop;
        drop          = 1'b0;
        bus.INTEGRAL  = r.area;
        bus.BASELINE  = r.baseline;
        bus.PEAK      = r.peak;
        bus.SATURATED = r.sat;
        bus.BUF_NUM   = r.buf_num;
        bus.TRIGGERED = 1'b1;
        tick(1);
        bus.BUF_NUM   = ~r.buf_num;
        bus.INTEGRAL  = ~r.area;
        bus.PEAK      = ~r.peak;
        tick(252);
        bus.INTEGRAL     = r.area;
        bus.PEAK         = r.peak;
        bus.RD_EN        = pop_at_cap;
        bus.CLR_OVERFLOW = clr_at_cap;
        if (pop_at_cap && sb.size() > 0) begin
            check({tag, "_cap_pop_head"}, 64'(dut_head()), 64'(sb[0]));
            void'(sb.pop_front());
        end
        if (sb.size() < CAPTURE_DEPTH) sb.push_back(r);
        else drop = 1'b1;
        model_ovf = drop ? 1'b1 : (clr_at_cap ? 1'b0 : model_ovf);
        tick(1);
        bus.RD_EN        = 1'b0;
        bus.CLR_OVERFLOW = 1'b0;
        bus.INTEGRAL     = ~r.area;
        bus.PEAK         = ~r.peak;
        tick(6);
        bus.TRIGGERED = 1'b0;
        tick(4);
        check_status(tag);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_nonempty"}, 64'(bus.EMPTY), 64'(0));
        check({tag, "_head"}, 64'(dut_head()), 64'(sb[0]));
        bus.RD_EN = 1'b1;
        tick(1);
        bus.RD_EN = 1'b0;
        void'(sb.pop_front());
        check({tag, "_count"}, 64'(bus.COUNT), 64'(sb.size()));
    endtask

    initial begin
        shwr_result_t r_nom;
        shwr_result_t r_rst;

        RESET            = 1'b1;
        bus.TRIGGERED    = 1'b0;
        bus.BUF_NUM      = '0;
        bus.INTEGRAL     = '0;
        bus.BASELINE     = '0;
        bus.PEAK         = '0;
        bus.SATURATED    = 1'b0;
        bus.RD_EN        = 1'b0;
        bus.CLR_OVERFLOW = 1'b0;
        tick(3);
        RESET = 1'b0;
        tick(1);

        // Reset state
        check_status("reset");
        check("reset_head", 64'(dut_head()), 64'(0));

        // Nominal event with exact capture timing
        r_nom = '{area: 24'h001234, baseline: 16'h0ABC, peak: 12'h123, sat: 1'b1, buf_num: 2'd2};
        sb.push_back(r_nom);
        bus.INTEGRAL  = r_nom.area;
        bus.BASELINE  = r_nom.baseline;
        bus.PEAK      = r_nom.peak;
        bus.SATURATED = r_nom.sat;
        bus.BUF_NUM   = 2'd2;
        bus.TRIGGERED = 1'b1;
        tick(1);
        bus.BUF_NUM = 2'd0;
        tick(252);
        check("nom_empty_at_capture", 64'(bus.EMPTY), 64'(1));
        tick(1);
        check("nom_empty_after", 64'(bus.EMPTY), 64'(0));
        check("nom_area", 64'(bus.AREA_OUT), 64'h1234);
        check("nom_bufnum", 64'(bus.BUF_NUM_OUT), 64'(2));
        tick(46);
        bus.TRIGGERED = 1'b0;
        tick(4);
        check_status("nom");
        pop_check("nom_pop");
        check("nom_hold_empty", 64'(bus.EMPTY), 64'(1));
        check("nom_hold_head", 64'(dut_head()), 64'(r_nom));

        // Aborted event
        bus.INTEGRAL  = 24'h005555;
        bus.TRIGGERED = 1'b1;
        tick(100);
        bus.TRIGGERED = 1'b0;
        tick(200);
        check_status("abort");

        // Overflow: five events, no reads; then a drop coinciding with a clear
        for (int i = 0; i < 5; i++) run_event($sformatf("ovf_ev%0d", i), mk(i), 1'b0, 1'b0);
        check("ovf_head_first", 64'(dut_head()), 64'(mk(0)));
        run_event("ovf_drop_clr", mk(5), 1'b0, 1'b1);
        bus.CLR_OVERFLOW = 1'b1;
        tick(1);
        bus.CLR_OVERFLOW = 1'b0;
        model_ovf = 1'b0;
        check("ovf_cleared", 64'(bus.OVERFLOW), 64'(0));
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_pop%0d", i));

        // Full FIFO with a pop on the capture cycle
        for (int i = 10; i < 14; i++) run_event($sformatf("fp_ev%0d", i), mk(i), 1'b0, 1'b0);
        run_event("fp_cap_pop", mk(14), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("fp_pop%0d", i));

        // Write with a simultaneous pop at one and at two entries
        run_event("wr1_ev", mk(20), 1'b0, 1'b0);
        run_event("wr1_cap_pop", mk(21), 1'b1, 1'b0);
        run_event("wr2_ev", mk(22), 1'b0, 1'b0);
        run_event("wr2_cap_pop", mk(23), 1'b1, 1'b0);
        pop_check("wr_pop0");
        pop_check("wr_pop1");

        // Reset in the middle of the window with the trigger still high
        sb.delete();
        model_ovf     = 1'b0;
        r_rst         = mk(30);
        bus.INTEGRAL  = r_rst.area;
        bus.BASELINE  = r_rst.baseline;
        bus.PEAK      = r_rst.peak;
        bus.SATURATED = r_rst.sat;
        bus.BUF_NUM   = r_rst.buf_num;
        bus.TRIGGERED = 1'b1;
        tick(120);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        check_status("rst_mid");
        sb.push_back(r_rst);
        tick(253);
        check("rst_empty_at_capture", 64'(bus.EMPTY), 64'(1));
        tick(1);
        check("rst_empty_after", 64'(bus.EMPTY), 64'(0));
        tick(25);
        bus.TRIGGERED = 1'b0;
        tick(4);
        check_status("rst_one_entry");
        pop_check("rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shwr_area_capture.md
SHWR_AREA_CAPTURE -- requirements
Module: shwr_area_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of result FIFO entries (power of two).
REQ-002 The block SHALL have parameter SETTLE, default 2, meaning the number of cycles after the last integrated bin before the integrator outputs are stable.
REQ-003 CLK120  in  1  clock; all logic SHALL be on its rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 TRIGGERED  in  1  shower trigger level (the same signal that drives the shower integrator).
REQ-006 BUF_NUM  in  2  shower buffer slot of the current event, sampled on the TRIGGERED rising edge.
REQ-007 INTEGRAL  in  `SHWR_AREA_WIDTH+`SHWR_AREA_FRAC_WIDTH  baseline-subtracted area from the integrator.
REQ-008 BASELINE  in  `ADC_WIDTH+`SHWR_AREA_FRAC_WIDTH  running baseline from the integrator.
REQ-009 PEAK  in  `ADC_WIDTH  peak above baseline; SATURATED  in  1  saturation flag.
REQ-010 RD_EN  in  1  pops the FIFO head; ignored when EMPTY.
REQ-011 CLR_OVERFLOW  in  1  clears OVERFLOW.
REQ-012 AREA_OUT, BASELINE_OUT, PEAK_OUT, SAT_OUT, BUF_NUM_OUT  out  widths as inputs  FIFO head fields (show-ahead).
REQ-013 EMPTY  out  1; FULL  out  1; COUNT  out  log2(DEPTH)+1  occupancy; OVERFLOW  out  1  sticky drop flag.

Function
REQ-014 FSM states: IDLE, ACCUM, CAPTURE, WAIT_LOW.
REQ-015 IDLE->ACCUM on a TRIGGERED rising edge (TRIGGERED=1 while the previous-cycle TRIGGERED=0); the window counter SHALL be 0 on the first TRIGGERED=1 cycle and BUF_NUM SHALL be latched on that cycle.
REQ-016 In ACCUM the counter SHALL increment every cycle; the state SHALL go to CAPTURE when the counter equals `SHWR_AREA_BINS+1+SETTLE.
REQ-017 If TRIGGERED falls while in ACCUM, the state SHALL return to IDLE with no FIFO write (aborted event).
REQ-018 CAPTURE SHALL last exactly one cycle, writing {INTEGRAL, BASELINE, PEAK, SATURATED, latched BUF_NUM} as sampled in that cycle, then go to WAIT_LOW.
REQ-019 WAIT_LOW->IDLE when TRIGGERED=0; a new rising edge SHALL NOT be recognised before this transition.
REQ-020 A write SHALL be accepted if COUNT<DEPTH, or if COUNT==DEPTH and RD_EN=1 in the same cycle (the pop is taken first).
REQ-021 A write refused because the FIFO is full SHALL drop the event and set OVERFLOW; the existing contents SHALL be unchanged.
REQ-022 OVERFLOW SHALL stay set until a CLR_OVERFLOW cycle; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-023 Simultaneous write and read on a non-full, non-empty FIFO SHALL leave COUNT unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 Head outputs SHALL change in the cycle after a pop or after a write into an empty FIFO (one-cycle latency).
REQ-026 While EMPTY=1 the head outputs SHALL hold their last values.
REQ-027 FULL SHALL be 1 exactly when COUNT==DEPTH; EMPTY SHALL be 1 exactly when COUNT==0.

Reset
REQ-028 RESET SHALL force state IDLE, counter 0, pointers 0, COUNT 0, EMPTY 1, FULL 0, OVERFLOW 0, all head outputs 0, and the TRIGGERED edge register 0.
REQ-029 RESET mid-ACCUM SHALL discard the event; if TRIGGERED is still high after reset releases, that SHALL count as a rising edge.

Structure
REQ-030 Widths and `SHWR_AREA_BINS SHALL come from sde_trigger_defs.vh; a new define `SHWR_CAPTURE_DEPTH (value 4) SHALL be added there.
REQ-031 The FIFO storage and pointers SHALL be one sub-module, shwr_result_fifo; the FSM SHALL live in the top module.

Verification (bench defs: ADC_WIDTH=12, SHWR_AREA_FRAC_WIDTH=4, SHWR_AREA_BINS=250, SETTLE=2)
REQ-032 Nominal: TRIGGERED high for 300 cycles, INTEGRAL=0x1234 held, BUF_NUM=2 -> one write at counter 253, EMPTY falls the next cycle, AREA_OUT=0x1234, BUF_NUM_OUT=2.
REQ-033 Abort: TRIGGERED high for 100 cycles -> no write, EMPTY stays 1, OVERFLOW stays 0.
REQ-034 Overflow: 5 full events with no reads -> COUNT=4, FULL=1, OVERFLOW=1, head = first event; 4 pops return events 1-4 in order.
REQ-035 Full plus simultaneous pop on the capture cycle -> write accepted, COUNT stays 4, OVERFLOW stays 0.
REQ-036 Reset at counter 120 with TRIGGERED held high 400 cycles -> capture at 253 cycles after release, exactly one entry.
REQ-037 CLR_OVERFLOW asserted in the same cycle as a dropped write -> OVERFLOW=1 afterwards; CLR_OVERFLOW alone the next cycle -> OVERFLOW=0.
